action_issuer: RTL and testbench
================================

// Module: action_issuer
// PURPOSE
//  Feeding end of the action_engine input interface. Takes a PHV plus its match result (hit, table address),
//  reads the per-address VLIW action word (25 sub-actions) from a locally configured action RAM and presents
//  PHV and action to action_engine with phv_valid_out and action_valid_out asserted in the same cycle.
//  One instance per pipeline stage, between the match table and action_engine.
// PARAMETERS
//  STAGE    0                           stage index; no functional effect
//  PHV_LEN  48*8+32*8+16*8+5*20+256     PHV width in bits (1124)
//  ACT_LEN  25                          bits per sub-action; action word = ACT_LEN*25 (625)
//  ADDR_W   4                           action RAM address width; depth = 2**ADDR_W (16)
// PORTS
//  clk              in   1                  clock
//  rst              in   1                  synchronous reset, active-high
//  phv_in           in   PHV_LEN            PHV from match stage
//  phv_valid_in     in   1                  phv_in valid, 1-cycle pulse per PHV
//  match_hit        in   1                  lookup hit; sampled only when phv_valid_in=1
//  match_addr       in   ADDR_W             action RAM address for a hit
//  cfg_wr_en        in   1                  action RAM write strobe
//  cfg_wr_addr      in   ADDR_W             write address
//  cfg_wr_data      in   ACT_LEN*25         action word to store
//  phv_out          out  PHV_LEN            PHV to action_engine.phv_in
//  phv_valid_out    out  1                  to action_engine.phv_valid_in
//  action_out       out  ACT_LEN*25         to action_engine.action_in
//  action_valid_out out  1                  to action_engine.action_valid_in; always equals phv_valid_out
//  hit_cnt          out  32                 PHVs issued with a stored action
//  miss_cnt         out  32                 PHVs issued with the default action
// BEHAVIOUR
//  - Clock clk, single domain. Reset rst is synchronous and active-high. No backpressure: action_engine
//    accepts one PHV per cycle, so back-to-back phv_valid_in is supported at full rate.
//  - Reset (rst=1 at a clk edge): phv_out=0, phv_valid_out=0, action_out=0, action_valid_out=0,
//    hit_cnt=0, miss_cnt=0, all 2**ADDR_W entry-valid bits cleared. RAM data is not cleared.
//    In-flight PHVs are dropped; no valid is emitted for a PHV accepted before reset.
//  - Pipeline: fixed 2-cycle latency. A PHV sampled with phv_valid_in=1 at edge N appears with
//    phv_valid_out=action_valid_out=1 after edge N+2, for exactly one cycle.
//    S1 (edge N): register phv, valid, eff_hit = match_hit & entry_valid[match_addr]; issue RAM read.
//    S2 (edge N+1): RAM data available. action_out = eff_hit ? ram[match_addr] : {ACT_LEN*25{1'b0}}.
//    All outputs registered at the final edge. The all-zero action word is the no-op action.
//  - When phv_valid_out=0, phv_out and action_out hold their last value; consumers ignore them.
//  - Config write: at an edge with cfg_wr_en=1, ram[cfg_wr_addr] <= cfg_wr_data and
//    entry_valid[cfg_wr_addr] <= 1. Writes are legal at any time, including during traffic.
//  - Write and read of the same address at the same edge: read-first. The PHV gets the old word
//    (or the default if the entry was not yet valid). The new word applies from the next PHV.
//  - match_hit=1 on an entry never written since reset is a miss: default action, miss_cnt increments.
//  - Counters: at S1, eff_hit=1 increments hit_cnt, otherwise miss_cnt increments; phv_valid_in=0 changes
//    neither. Each counter saturates at 32'hFFFF_FFFF and does not wrap.
//  - match_hit and match_addr are don't-care when phv_valid_in=0.
// TESTING
//  T1 reset: hold rst for 3 cycles with phv_valid_in=1 -> all outputs 0, no valid pulse for 2 cycles
//     after rst falls.
//  T2 hit: write addr 3 = 625'h1ABC; PHV P1, hit=1, addr=3 -> 2 cycles later phv_out=P1,
//     action_out=625'h1ABC, both valids=1 for 1 cycle, hit_cnt=1.
//  T3 miss / unwritten entry: PHV with hit=0; then PHV with hit=1, addr=7 (never written)
//     -> action_out=0 both times, miss_cnt=2.
//  T4 back-to-back: 16 consecutive PHVs, addr 0..15 all written with addr+1 -> 16 consecutive valid
//     cycles, action_out=1..16 in order, PHVs unchanged.
//  T5 collision: addr 5 = A; same edge: cfg write addr 5 = B and PHV hit addr 5 -> that PHV gets A,
//     next PHV to addr 5 gets B.
//  T6 saturation / mid-flight reset: force miss_cnt=32'hFFFF_FFFE, send 3 misses -> stays 32'hFFFF_FFFF;
//     assert rst 1 cycle after a PHV enters -> no valid pulse emitted for it.

Source files
------------

// File: rtl/action_issuer.sv
// action_issuer: feeds action_engine with a PHV and its VLIW action word.
// A locally written action RAM is read with the match address. The PHV and
// the selected action come out together two edges after the PHV is accepted.
// Pipeline: accept edge (S1) -> data edge (S2) -> output edge.
module action_issuer #(
  parameter int STAGE   = 0,
  parameter int PHV_LEN = 48*8 + 32*8 + 16*8 + 5*20 + 256,
  parameter int ACT_LEN = 25,
  parameter int ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PHV_LEN-1:0]     phv_in,
  input  logic                   phv_valid_in,
  input  logic                   match_hit,
  input  logic [ADDR_W-1:0]      match_addr,
  input  logic                   cfg_wr_en,
  input  logic [ADDR_W-1:0]      cfg_wr_addr,
  input  logic [ACT_LEN*25-1:0]  cfg_wr_data,
  output logic [PHV_LEN-1:0]     phv_out,
  output logic                   phv_valid_out,
  output logic [ACT_LEN*25-1:0]  action_out,
  output logic                   action_valid_out,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  // STAGE is an informational tag only; it folds to zero here.
  localparam int DEPTH = (2 ** ADDR_W) + 0 * STAGE;
  localparam int ACT_W = ACT_LEN * 25;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Action RAM storage; contents survive reset, only the valid bits are cleared.
  logic [ACT_W-1:0]   ram_q [DEPTH];

  logic [DEPTH-1:0]   entry_vld_q, entry_vld_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  // S1: PHV accepted, effective hit resolved, RAM word captured.
  logic               s1_valid_q, s1_valid_d;
  logic               s1_hit_q, s1_hit_d;
  logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d;
  logic [ACT_W-1:0]   s1_rdata_q, s1_rdata_d;

  // S2: action word selected (stored word or the all-zero no-op).
  logic               s2_valid_q, s2_valid_d;
  logic [PHV_LEN-1:0] s2_phv_q, s2_phv_d;
  logic [ACT_W-1:0]   s2_act_q, s2_act_d;

  // Output registers toward action_engine.
  logic               out_valid_q, out_valid_d;
  logic [PHV_LEN-1:0] out_phv_q, out_phv_d;
  logic [ACT_W-1:0]   out_act_q, out_act_d;

  logic               eff_hit;

  // Next-state for entry valids, counters and the three pipeline stages.
  always_comb begin
    entry_vld_d = entry_vld_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    s1_valid_d  = phv_valid_in;
    s1_hit_d    = s1_hit_q;
    s1_phv_d    = s1_phv_q;
    s1_rdata_d  = s1_rdata_q;
    s2_valid_d  = s1_valid_q;
    s2_phv_d    = s2_phv_q;
    s2_act_d    = s2_act_q;
    out_valid_d = s2_valid_q;
    out_phv_d   = out_phv_q;
    out_act_d   = out_act_q;

    // An entry never written since reset behaves as a miss; the valid bit is
    // sampled before this edge's write, so a colliding write is not seen yet.
    eff_hit = match_hit & entry_vld_q[match_addr];

    if (cfg_wr_en) begin
      entry_vld_d[cfg_wr_addr] = 1'b1;
    end

    if (phv_valid_in) begin
      s1_hit_d   = eff_hit;
      s1_phv_d   = phv_in;
      // ram_q still holds the pre-write word at this edge: read-first.
      s1_rdata_d = ram_q[match_addr];
      if (eff_hit) begin
        if (hit_cnt_q != CNT_MAX) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end
      end else begin
        if (miss_cnt_q != CNT_MAX) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
    end

    if (s1_valid_q) begin
      s2_phv_d = s1_phv_q;
      s2_act_d = s1_hit_q ? s1_rdata_q : '0;
    end

    // Data outputs hold their last value while no PHV is being presented.
    if (s2_valid_q) begin
      out_phv_d = s2_phv_q;
      out_act_d = s2_act_q;
    end
  end

  // Control state with synchronous reset; in-flight valids are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_vld_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_phv_q   <= '0;
      out_act_q   <= '0;
    end else begin
      entry_vld_q <= entry_vld_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_phv_q   <= out_phv_d;
      out_act_q   <= out_act_d;
    end
  end

  // Pipeline data registers; qualified by the valids, so no reset needed.
  always_ff @(posedge clk) begin
    s1_hit_q   <= s1_hit_d;
    s1_phv_q   <= s1_phv_d;
    s1_rdata_q <= s1_rdata_d;
    s2_phv_q   <= s2_phv_d;
    s2_act_q   <= s2_act_d;
  end

  // Action RAM write port; writes are accepted at any time.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
      ram_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  assign phv_out          = out_phv_q;
  assign phv_valid_out    = out_valid_q;
  assign action_out       = out_act_q;
  assign action_valid_out = out_valid_q;
  assign hit_cnt          = hit_cnt_q;
  assign miss_cnt         = miss_cnt_q;

endmodule

// File: tb/tb_action_issuer.sv
// Bench for action_issuer: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_action_issuer;

  localparam int PHV_LEN = 48*8 + 32*8 + 16*8 + 5*20 + 256;
  localparam int ACT_W   = 25 * 25;
  localparam int AW      = 4;
  localparam int WIDE    = PHV_LEN;

  logic               clk;
  logic               rst;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid_in;
  logic               match_hit;
  logic [AW-1:0]      match_addr;
  logic               cfg_wr_en;
  logic [AW-1:0]      cfg_wr_addr;
  logic [ACT_W-1:0]   cfg_wr_data;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out;
  logic [ACT_W-1:0]   action_out;
  logic               action_valid_out;
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;

  action_issuer dut (
    .clk              (clk),
    .rst              (rst),
    .phv_in           (phv_in),
    .phv_valid_in     (phv_valid_in),
    .match_hit        (match_hit),
    .match_addr       (match_addr),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_data      (cfg_wr_data),
    .phv_out          (phv_out),
    .phv_valid_out    (phv_valid_out),
    .action_out       (action_out),
    .action_valid_out (action_valid_out),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [WIDE-1:0] got, input logic [WIDE-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (low 256 bits)", name, got[255:0], exp[255:0]);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                 due;
    logic [PHV_LEN-1:0] phv;
    logic [ACT_W-1:0]   act;
  } item_t;

  item_t              pend[$];
  logic [ACT_W-1:0]   m_ram [16];
  bit                 m_vld [16];
  logic [31:0]        m_hit = 0;
  logic [31:0]        m_miss = 0;
  bit                 e_valid = 0;
  logic [PHV_LEN-1:0] e_phv = '0;
  logic [ACT_W-1:0]   e_act = '0;
  bit                 model_live = 0;
  int                 cyc = 0;

  always @(posedge clk) begin
    item_t it;
    cyc++;
    if (rst) begin
      pend.delete();
      for (int i = 0; i < 16; i++) m_vld[i] = 0;
      m_hit = 0;
      m_miss = 0;
      e_valid = 0;
      e_phv = '0;
      e_act = '0;
      model_live = 1;
    end else begin
      if (phv_valid_in) begin
        it.due = cyc + 2;
        it.phv = phv_in;
        if (match_hit && m_vld[match_addr]) begin
          it.act = m_ram[match_addr];
          if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
        end else begin
          it.act = '0;
          if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
        end
        pend.push_back(it);
      end
      if (cfg_wr_en) begin
        m_ram[cfg_wr_addr] = cfg_wr_data;
        m_vld[cfg_wr_addr] = 1;
      end
      e_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_valid = 1;
        e_phv = pend[0].phv;
        e_act = pend[0].act;
        void'(pend.pop_front());
      end
    end
  end

  // Compare process: one sample per cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      check("phv_valid_out", WIDE'(phv_valid_out), WIDE'(e_valid));
      check("action_valid_out", WIDE'(action_valid_out), WIDE'(e_valid));
      check("hit_cnt", WIDE'(hit_cnt), WIDE'(m_hit));
      check("miss_cnt", WIDE'(miss_cnt), WIDE'(m_miss));
      if (e_valid) begin
        check("phv_out", phv_out, e_phv);
        check("action_out", WIDE'(action_out), WIDE'(e_act));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] v = '0;
    for (int k = 0; k < 36; k++) v = {v[PHV_LEN-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [ACT_W-1:0] rand_act();
    logic [ACT_W-1:0] v = '0;
    for (int k = 0; k < 20; k++) v = {v[ACT_W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    phv_valid_in = 1'b0;
    cfg_wr_en    = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic send(input logic hit, input logic [AW-1:0] addr, input logic [PHV_LEN-1:0] p);
    phv_valid_in = 1'b1;
    match_hit    = hit;
    match_addr   = addr;
    phv_in       = p;
  endtask

  task automatic cfg(input logic [AW-1:0] addr, input logic [ACT_W-1:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = addr;
    cfg_wr_data = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PHV_LEN-1:0] p1;
    logic [PHV_LEN-1:0] pv [16];

    rst = 1'b1;
    phv_valid_in = 1'b1;
    match_hit = 1'b1;
    match_addr = '0;
    phv_in = rand_phv();
    cfg_wr_en = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;

    // T1: three reset edges with valid asserted, then two quiet cycles.
    step(); step(); step();
    idle();
    step();
    check("T1 valid+1", WIDE'(phv_valid_out), WIDE'(0));
    check("T1 phv_out", phv_out, WIDE'(0));
    step();
    check("T1 valid+2", WIDE'(phv_valid_out), WIDE'(0));
    check("T1 action_out", WIDE'(action_out), WIDE'(0));

    // T2: hit on a written entry.
    cfg(4'd3, 625'h1ABC);
    step();
    idle();
    p1 = rand_phv();
    send(1'b1, 4'd3, p1);
    step();
    idle();
    step(); step();
    check("T2 valid", WIDE'(phv_valid_out), WIDE'(1));
    check("T2 action_out", WIDE'(action_out), WIDE'(625'h1ABC));
    check("T2 phv_out", phv_out, p1);
    check("T2 hit_cnt", WIDE'(hit_cnt), WIDE'(1));
    step();
    check("T2 single pulse", WIDE'(phv_valid_out), WIDE'(0));

    // T3: plain miss, then hit on a never-written entry.
    send(1'b0, 4'd3, rand_phv());
    step();
    send(1'b1, 4'd7, rand_phv());
    step();
    idle();
    step(); step();
    check("T3 valid", WIDE'(phv_valid_out), WIDE'(1));
    check("T3 action_out", WIDE'(action_out), WIDE'(0));
    check("T3 miss_cnt", WIDE'(miss_cnt), WIDE'(2));

    // T4: fill all entries with addr+1, then 16 back-to-back hits.
    for (int i = 0; i < 16; i++) begin
      cfg(AW'(i), ACT_W'(i + 1));
      step();
    end
    idle();
    for (int i = 0; i < 16; i++) pv[i] = rand_phv();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) send(1'b1, AW'(i), pv[i]);
      else idle();
      step();
      if (i >= 2) begin
        check("T4 valid", WIDE'(phv_valid_out), WIDE'(1));
        check("T4 action_out", WIDE'(action_out), WIDE'(i - 1));
        check("T4 phv_out", phv_out, pv[i-2]);
      end
    end
    idle();
    check("T4 hit_cnt", WIDE'(hit_cnt), WIDE'(17));

    // T5: write and read of addr 5 at the same edge; old word wins.
    cfg(4'd5, 625'hB0B);
    send(1'b1, 4'd5, rand_phv());
    step();
    cfg_wr_en = 1'b0;
    send(1'b1, 4'd5, rand_phv());
    step();
    idle();
    step();
    check("T5 first action", WIDE'(action_out), WIDE'(6));
    step();
    check("T5 second action", WIDE'(action_out), WIDE'(625'hB0B));

    // T6: saturation of miss_cnt, then reset while a PHV is in flight.
    step();
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    m_miss = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt_q;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, AW'(i), rand_phv());
      step();
    end
    idle();
    step(); step();
    check("T6 miss saturated", WIDE'(miss_cnt), WIDE'(32'hFFFF_FFFF));
    send(1'b1, 4'd2, rand_phv());
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("T6 dropped +2", WIDE'(phv_valid_out), WIDE'(0));
    check("T6 hit_cnt reset", WIDE'(hit_cnt), WIDE'(0));
    step();
    check("T6 dropped +3", WIDE'(phv_valid_out), WIDE'(0));
    check("T6 miss_cnt reset", WIDE'(miss_cnt), WIDE'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      phv_valid_in = ($urandom_range(0, 9) < 7);
      match_hit    = ($urandom_range(0, 9) < 7);
      match_addr   = AW'($urandom);
      phv_in       = rand_phv();
      cfg_wr_en    = ($urandom_range(0, 4) == 0);
      cfg_wr_addr  = ($urandom_range(0, 3) == 0) ? match_addr : AW'($urandom);
      cfg_wr_data  = rand_act();
      step();
    end
    idle();
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
